// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle sequencer: arbitrates for the bus, runs DMA transfers, releases on last/error/tenure limit.
// Optional DATA-phase timeout is compiled in when the macro Z3M_TIMEOUT_EN is defined.
module z3_master_cycle #(
    parameter int unsigned MAX_TENURE = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       dma_req,
    input  logic       dma_read,
    input  logic [3:0] dma_be,
    input  logic       dma_last,
    output logic       dma_ack,
    output logic       dma_err,
    output logic       SBR_n,
    input  logic       SBG_n,
    input  logic       DTACK_n,
    input  logic       BERR_n,
    output logic       MASTER,
    output logic       FCS_n_out,
    output logic [3:0] DS_n_out,
    output logic       READ_out
);
    localparam int unsigned TW = $clog2(MAX_TENURE + 1);
    localparam logic [TW-1:0] TEN_MAX = TW'(MAX_TENURE);

    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must fit the 8-bit DATA counter");
    end

    typedef enum logic [2:0] {IDLE, ARB, OWN, ADDR, DATA, TERM, RELEASE} state_t;
    state_t state, state_nx;

    logic [1:0]    sbg_sync, dtack_sync, berr_sync;
    logic          sbg, dtack, berr;
    logic          rd_lat, last_lat, err_lat;
    logic [3:0]    be_lat;
    logic [TW-1:0] tenure;
    logic          tmo_hit;

    logic          sbr_nx, master_nx, fcs_nx, read_nx, ack_nx, err_nx;
    logic [3:0]    ds_nx;

    assign sbg   = sbg_sync[1];
    assign dtack = dtack_sync[1];
    assign berr  = berr_sync[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sbg_sync   <= '1;
            dtack_sync <= '1;
            berr_sync  <= '1;
            state      <= IDLE;
            SBR_n      <= 1'b1;
            MASTER     <= 1'b0;
            FCS_n_out  <= 1'b1;
            DS_n_out   <= '1;
            READ_out   <= 1'b1;
            dma_ack    <= 1'b0;
            dma_err    <= 1'b0;
            rd_lat     <= 1'b1;
            be_lat     <= '0;
            last_lat   <= 1'b0;
            err_lat    <= 1'b0;
            tenure     <= '0;
        end else begin
            sbg_sync   <= {sbg_sync[0], SBG_n};
            dtack_sync <= {dtack_sync[0], DTACK_n};
            berr_sync  <= {berr_sync[0], BERR_n};
            state      <= state_nx;
            SBR_n      <= sbr_nx;
            MASTER     <= master_nx;
            FCS_n_out  <= fcs_nx;
            DS_n_out   <= ds_nx;
            READ_out   <= read_nx;
            dma_ack    <= ack_nx;
            dma_err    <= err_nx;
            if (state_nx == OWN) begin
                rd_lat   <= dma_read;
                be_lat   <= dma_be;
                last_lat <= dma_last;
            end
            if (ack_nx)
                err_lat <= err_nx;
            if (state == RELEASE)
                tenure <= '0;
            else if (ack_nx)
                tenure <= tenure + TW'(1);
        end
    end

`ifdef Z3M_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge CLK) begin
        if (RST || state != DATA)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Decision one count early so the ack lands TIMEOUT edges after DATA entry.
    assign tmo_hit = (state == DATA) && (tmo_cnt == 8'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (dma_req) state_nx = ARB;
            ARB:     if (!dma_req) state_nx = IDLE;
                     else if (!sbg && dtack) state_nx = OWN;
            OWN:     state_nx = ADDR;
            ADDR:    state_nx = DATA;
            DATA:    if (!berr || !dtack || tmo_hit) state_nx = TERM;
            TERM:    if (dtack && berr) begin
                         if (dma_req && !last_lat && !err_lat && tenure < TEN_MAX)
                             state_nx = OWN;
                         else
                             state_nx = RELEASE;
                     end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they can be registered.
    always_comb begin
        sbr_nx    = 1'b1;
        master_nx = 1'b0;
        fcs_nx    = 1'b1;
        ds_nx     = '1;
        read_nx   = 1'b1;
        ack_nx    = 1'b0;
        err_nx    = 1'b0;
        case (state_nx)
            ARB:  sbr_nx = 1'b0;
            OWN: begin
                master_nx = 1'b1;
                read_nx   = dma_read;
            end
            ADDR: begin
                master_nx = 1'b1;
                fcs_nx    = 1'b0;
                read_nx   = rd_lat;
            end
            DATA: begin
                master_nx = 1'b1;
                fcs_nx    = 1'b0;
                read_nx   = rd_lat;
                // Writes hold DS off for the first DATA cycle (FCS low two cycles first).
                if (rd_lat || state == DATA)
                    ds_nx = ~be_lat;
            end
            TERM: begin
                master_nx = 1'b1;
                read_nx   = rd_lat;
                if (state == DATA) begin
                    ack_nx = 1'b1;
                    err_nx = !berr || (dtack && tmo_hit);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_z3_master_cycle.sv
// Directed bench for z3_master_cycle: hand-timed literal checks plus a per-cycle protocol/scoreboard compare.
`timescale 1ns/1ps
module tb_z3_master_cycle;
    localparam int unsigned MAXT = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       dma_req = 1'b0, dma_read = 1'b0, dma_last = 1'b0;
    logic [3:0] dma_be = '0;
    logic       SBG_n = 1'b1, DTACK_n = 1'b1, BERR_n = 1'b1;
    logic       dma_ack, dma_err, SBR_n, MASTER, FCS_n_out, READ_out;
    logic [3:0] DS_n_out;

    int checks = 0;
    int failures = 0;

    // Model: transaction in flight and protocol history
    logic       tx_read = 1'b0;
    logic [3:0] tx_be = '0;
    logic       exp_err = 1'b0;
    logic       p_fcs = 1'b1, p_master = 1'b0, p_sbr = 1'b1;
    logic [3:0] p_ds = 4'hF;
    int         fcs_run = 0;
    int         ten_acks = 0;
    int         ack_total = 0;
    int         tenures[$];
    logic       master_seen = 1'b0;

    z3_master_cycle #(.MAX_TENURE(MAXT), .TIMEOUT(255)) dut (
        .CLK(CLK), .RST(RST),
        .dma_req(dma_req), .dma_read(dma_read), .dma_be(dma_be), .dma_last(dma_last),
        .dma_ack(dma_ack), .dma_err(dma_err),
        .SBR_n(SBR_n), .SBG_n(SBG_n), .DTACK_n(DTACK_n), .BERR_n(BERR_n),
        .MASTER(MASTER), .FCS_n_out(FCS_n_out), .DS_n_out(DS_n_out), .READ_out(READ_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare();
        logic [3:0] exp_ds;
        exp_ds = ~tx_be;
        if (RST) begin
            p_fcs = 1'b1; p_master = 1'b0; p_sbr = 1'b1; p_ds = 4'hF;
            fcs_run = 0; ten_acks = 0;
            return;
        end
        if (MASTER) master_seen = 1'b1;
        if (!MASTER) chk("idle_strobes", 32'({FCS_n_out, DS_n_out}), 32'h1F);
        if (DS_n_out != 4'hF) begin
            chk("ds_pattern", 32'(DS_n_out), 32'(exp_ds));
            chk("ds_fcs", 32'(FCS_n_out), 0);
            chk("ds_read", 32'(READ_out), 32'(tx_read));
            if (p_ds == 4'hF) chk("ds_setup", fcs_run, tx_read ? 1 : 2);
        end
        if (dma_ack) begin
            chk("ack_after_ds", 32'(p_ds), 32'(exp_ds));
            chk("ack_strobes", 32'({FCS_n_out, DS_n_out}), 32'h1F);
            chk("ack_err", 32'(dma_err), 32'(exp_err));
            chk("ack_tenure", 32'(ten_acks < MAXT), 1);
            ten_acks++;
            ack_total++;
        end
        if (MASTER && !p_master) chk("grant_after_req", 32'(p_sbr), 0);
        if (!MASTER && p_master) begin
            tenures.push_back(ten_acks);
            ten_acks = 0;
        end
        if (!FCS_n_out && p_fcs) chk("own_before_fcs", 32'(p_master), 1);
        fcs_run  = FCS_n_out ? 0 : fcs_run + 1;
        p_fcs    = FCS_n_out;
        p_master = MASTER;
        p_sbr    = SBR_n;
        p_ds     = DS_n_out;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            compare();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sbr"}, 32'(SBR_n), 1);
        chk({tag, "_master"}, 32'(MASTER), 0);
        chk({tag, "_fcs"}, 32'(FCS_n_out), 1);
        chk({tag, "_ds"}, 32'(DS_n_out), 32'hF);
        chk({tag, "_read"}, 32'(READ_out), 1);
        chk({tag, "_ack"}, 32'(dma_ack), 0);
        chk({tag, "_err"}, 32'(dma_err), 0);
    endtask

    task automatic start_xfer(input logic rd, input logic [3:0] be, input logic last, output logic ok);
        int n = 0;
        tx_read = rd; tx_be = be;
        dma_read = rd; dma_be = be; dma_last = last; dma_req = 1'b1;
        while (DS_n_out == 4'hF && n < 200) begin
            step(1);
            n++;
        end
        ok = (DS_n_out != 4'hF);
        chk("ds_reached", 32'(ok), 1);
    endtask

    task automatic finish_xfer(input logic berr);
        int n = 0;
        exp_err = berr;
        DTACK_n = 1'b0;
        if (berr) BERR_n = 1'b0;
        while (!dma_ack && n < 50) begin
            step(1);
            n++;
        end
        chk("ack_latency", n, 3);
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;
    endtask

    initial begin
        logic       ok;
        logic [3:0] be_v;
        int         a0;
        int         n;
        int         exp_acks;

        RST = 1'b1;
        step(3);
        check_reset_vals("por");
        RST = 1'b0;
        step(2);
        chk("idle_sbr", 32'(SBR_n), 1);

        // Single read, hand-timed from request
        tx_read = 1'b1; tx_be = 4'hF; exp_err = 1'b0;
        dma_read = 1'b1; dma_be = 4'hF; dma_last = 1'b1; dma_req = 1'b1;
        step(1); chk("arb_sbr", 32'(SBR_n), 0);
        step(4); SBG_n = 1'b0;
        step(2); chk("grant_sync_wait", 32'(MASTER), 0);
        step(1); chk("own_master", 32'(MASTER), 1); chk("own_sbr", 32'(SBR_n), 1);
        step(1); chk("addr_fcs", 32'(FCS_n_out), 0); chk("addr_ds", 32'(DS_n_out), 32'hF);
        DTACK_n = 1'b0;
        step(1); chk("read_ds", 32'(DS_n_out), 0); chk("read_out", 32'(READ_out), 1);
        step(1); chk("ack_not_early", 32'(dma_ack), 0);
        step(1); chk("read_ack", 32'(dma_ack), 1); chk("read_err", 32'(dma_err), 0);
        dma_req = 1'b0; DTACK_n = 1'b1; SBG_n = 1'b1;
        step(1); chk("ack_pulse", 32'(dma_ack), 0); chk("term_master", 32'(MASTER), 1);
        step(2); chk("release_master", 32'(MASTER), 0);
        step(1); chk("idle_master", 32'(MASTER), 0); chk("idle_sbr2", 32'(SBR_n), 1);

        // Request withdrawn before grant
        master_seen = 1'b0; a0 = ack_total;
        dma_req = 1'b1;
        step(1); chk("wd_sbr_low", 32'(SBR_n), 0);
        step(2); dma_req = 1'b0;
        step(1); chk("wd_sbr_high", 32'(SBR_n), 1);
        step(5); chk("wd_no_master", 32'(master_seen), 0); chk("wd_no_ack", ack_total, a0);

        // BERR together with DTACK, request kept high
        tenures.delete(); SBG_n = 1'b0;
        start_xfer(1'b0, 4'b0101, 1'b0, ok);
        if (ok) finish_xfer(1'b1);
        chk("berr_err", 32'(dma_err), 1);
        step(3); chk("berr_release", 32'(MASTER), 0);
        dma_req = 1'b0;
        step(3); chk("berr_sbr", 32'(SBR_n), 1);
        chk("berr_tenures", tenures.size(), 1);

        // Burst of 20 writes with last=0
        tenures.delete(); a0 = ack_total;
        for (int i = 0; i < 20; i++) begin
            be_v = 4'((i % 15) + 1);
            start_xfer(1'b0, be_v, 1'b0, ok);
            if (!ok) break;
            finish_xfer(1'b0);
        end
        dma_req = 1'b0;
        step(4);
        chk("burst_acks", ack_total - a0, 20);
        chk("burst_tenure_count", tenures.size(), 2);
        if (tenures.size() == 2) begin
            chk("burst_tenure0", tenures[0], 16);
            chk("burst_tenure1", tenures[1], 4);
        end

        // Stalled DATA phase, then reset mid-cycle
        a0 = ack_total; exp_err = 1'b1;
        start_xfer(1'b1, 4'hC, 1'b1, ok);
`ifdef Z3M_TIMEOUT_EN
        n = 0;
        while (!dma_ack && n < 400) begin
            step(1);
            n++;
        end
        chk("timeout_cycles", n, 255);
        chk("timeout_err", 32'(dma_err), 1);
        dma_req = 1'b0;
        step(6); chk("timeout_release", 32'(MASTER), 0);
        start_xfer(1'b1, 4'hC, 1'b1, ok);
        exp_acks = a0 + 1;
`else
        n = 0;
        step(1000);
        chk("no_timeout_ack", ack_total, a0);
        chk("still_in_data", 32'(FCS_n_out), 0);
        exp_acks = a0;
`endif
        step(3);
        RST = 1'b1;
        step(1);
        check_reset_vals("midrst");
        chk("midrst_acks", ack_total, exp_acks);
        RST = 1'b0; dma_req = 1'b0;
        step(2);
        chk("post_rst_master", 32'(MASTER), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
